// File: rtl/si_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : si_pkg                                                 |
// | Description : Shared constants and types for the button conditioner. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package si_pkg;

  localparam int CLK_HZ = 100_000_000;

  // Default timing at 100 MHz: 10 ms debounce, 20 ms repeat, 250 ms cooldown
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_MOVE_PERIOD     = CLK_HZ / 50;
  localparam int DEF_SHOOT_COOLDOWN  = CLK_HZ / 4;
  localparam int DEF_CNT_W           = 25;

  // Index of each button inside the debounced vectors
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_SHOOT = 2;
  localparam int BTN_RST   = 3;

  typedef enum logic [0:0] {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } shoot_state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : btn_debounce                                           |
// | Description : 2-FF synchroniser, counting debouncer and rise pulse.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module btn_debounce
  import si_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int              CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Count while the synchronised input disagrees; accept it after a full window
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == C_LAST) begin
        stable_d = ~stable_q;
        rise_d   = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser chain and debouncer state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : btn_conditioner                                        |
// | Description : Debounces four buttons and turns them into one-cycle   |
// |               move ticks (auto-repeat), rate-limited shots and a     |
// |               reset request.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module btn_conditioner
  import si_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MOVE_PERIOD     = DEF_MOVE_PERIOD,
  parameter int SHOOT_COOLDOWN  = DEF_SHOOT_COOLDOWN,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_shoot,
  input  logic btn_rst,
  output logic move_right,
  output logic move_left,
  output logic shoot,
  output logic reset_req,
  output logic right_held,
  output logic left_held
);

  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(SHOOT_COOLDOWN - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;

  assign btn_raw = {btn_rst, btn_shoot, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_raw[i]),
      .level  (btn_level[i]),
      .rise   (btn_rise[i])
    );
  end

  // Shoot and reset are edge-driven only; their levels are not consumed
  logic unused_levels;
  assign unused_levels = ^btn_level[BTN_RST:BTN_SHOOT];

  // ---------------- movement with auto-repeat ----------------
  logic             only_right, only_left;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  dir_e             dir_q, dir_d;
  logic             move_right_q, move_right_d;
  logic             move_left_q, move_left_d;

  assign only_right = btn_level[BTN_RIGHT] & ~btn_level[BTN_LEFT];
  assign only_left  = btn_level[BTN_LEFT]  & ~btn_level[BTN_RIGHT];

  // A direction that just became the sole active one ticks at once, then repeats
  always_comb begin
    rpt_d        = '0;
    dir_d        = DIR_NONE;
    move_right_d = 1'b0;
    move_left_d  = 1'b0;
    if (only_right) begin
      dir_d = DIR_RIGHT;
      if (btn_rise[BTN_RIGHT] || (dir_q != DIR_RIGHT) || (rpt_q == RPT_LAST)) begin
        move_right_d = 1'b1;
      end else begin
        rpt_d = rpt_q + CNT_W'(1);
      end
    end else if (only_left) begin
      dir_d = DIR_LEFT;
      if (btn_rise[BTN_LEFT] || (dir_q != DIR_LEFT) || (rpt_q == RPT_LAST)) begin
        move_left_d = 1'b1;
      end else begin
        rpt_d = rpt_q + CNT_W'(1);
      end
    end
  end

  // Movement registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q        <= '0;
      dir_q        <= DIR_NONE;
      move_right_q <= 1'b0;
      move_left_q  <= 1'b0;
    end else begin
      rpt_q        <= rpt_d;
      dir_q        <= dir_d;
      move_right_q <= move_right_d;
      move_left_q  <= move_left_d;
    end
  end

  // ---------------- shoot rate limiter and reset request ----------------
  shoot_state_e     state_q;
  logic [CNT_W-1:0] cd_q;
  logic             shoot_q;
  logic             reset_req_q;

  // Presses arriving during cooldown are dropped, never queued
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_READY;
      cd_q        <= '0;
      shoot_q     <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      shoot_q     <= 1'b0;
      reset_req_q <= btn_rise[BTN_RST];
      case (state_q)
        ST_READY: begin
          if (btn_rise[BTN_SHOOT]) begin
            shoot_q <= 1'b1;
            state_q <= ST_COOLDOWN;
            cd_q    <= '0;
          end
        end
        ST_COOLDOWN: begin
          if (cd_q == CD_LAST) begin
            state_q <= ST_READY;
            cd_q    <= '0;
          end else begin
            cd_q <= cd_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign move_right = move_right_q;
  assign move_left  = move_left_q;
  assign shoot      = shoot_q;
  assign reset_req  = reset_req_q;
  assign right_held = btn_level[BTN_RIGHT];
  assign left_held  = btn_level[BTN_LEFT];

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_btn_conditioner                                     |
// | Description : Directed self-checking bench for btn_conditioner.      |
// |               Cycle c = observation just after the c-th rising edge  |
// |               of a scenario; inputs change right after observation.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int MOVE = 8;
  localparam int COOL = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_right = 1'b0;
  logic btn_left = 1'b0;
  logic btn_shoot = 1'b0;
  logic btn_rst = 1'b0;
  logic move_right, move_left, shoot, reset_req, right_held, left_held;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .MOVE_PERIOD     (MOVE),
    .SHOOT_COOLDOWN  (COOL),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .btn_shoot  (btn_shoot),
    .btn_rst    (btn_rst),
    .move_right (move_right),
    .move_left  (move_left),
    .shoot      (shoot),
    .reset_req  (reset_req),
    .right_held (right_held),
    .left_held  (left_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({move_right, move_left, shoot, reset_req, right_held, left_held} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=000000",
               {move_right, move_left, shoot, reset_req, right_held, left_held});
    end
    rst = 1'b0;
    idle(3);
    checks++;
    if ({move_right, move_left, shoot, reset_req, right_held, left_held} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b expected=000000",
               {move_right, move_left, shoot, reset_req, right_held, left_held});
    end
  endtask

  task automatic test_shoot_hold();
    logic exp;
    for (int c = 1; c <= 115; c++) begin
      tick();
      exp = (c == 17);
      checks++;
      if (shoot !== exp) begin
        errors++;
        $display("FAIL shoot_hold c=%0d shoot=%b expected=%b", c, shoot, exp);
      end
      if (c == 10)  btn_shoot = 1'b1;
      if (c == 110) btn_shoot = 1'b0;
    end
    idle(10);
  endtask

  task automatic test_glitch();
    btn_left = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      checks++;
      if (move_left !== 1'b0 || left_held !== 1'b0) begin
        errors++;
        $display("FAIL glitch c=%0d move_left=%b left_held=%b expected=0,0", c, move_left, left_held);
      end
      if (c < 40) btn_left = ((c / 2) % 2 == 0);
      else        btn_left = 1'b0;
    end
    idle(5);
  endtask

  task automatic test_right_hold();
    logic exp_mv, exp_held;
    btn_right = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      tick();
      exp_mv   = (c == 7) || (c == 15) || (c == 23) || (c == 31) || (c == 39);
      exp_held = (c >= 6) && (c <= 45);
      checks++;
      if (move_right !== exp_mv) begin
        errors++;
        $display("FAIL right_repeat c=%0d move_right=%b expected=%b", c, move_right, exp_mv);
      end
      checks++;
      if (right_held !== exp_held) begin
        errors++;
        $display("FAIL right_held c=%0d right_held=%b expected=%b", c, right_held, exp_held);
      end
      checks++;
      if (move_left !== 1'b0) begin
        errors++;
        $display("FAIL right_no_left c=%0d move_left=%b expected=0", c, move_left);
      end
      if (c == 40) btn_right = 1'b0;
    end
    idle(5);
  endtask

  task automatic test_both_held();
    logic exp_l, exp_r;
    btn_left = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      tick();
      exp_l = (c == 7) || (c == 15);
      exp_r = (c == 37) || (c == 45) || (c == 53) || (c == 61);
      checks++;
      if (move_left !== exp_l) begin
        errors++;
        $display("FAIL both_left c=%0d move_left=%b expected=%b", c, move_left, exp_l);
      end
      checks++;
      if (move_right !== exp_r) begin
        errors++;
        $display("FAIL both_right c=%0d move_right=%b expected=%b", c, move_right, exp_r);
      end
      if (c == 10) btn_right = 1'b1;
      if (c == 30) btn_left  = 1'b0;
      if (c == 60) btn_right = 1'b0;
    end
    idle(10);
  endtask

  task automatic test_shoot_cooldown();
    logic exp;
    btn_shoot = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      exp = (c == 7) || (c == 24);
      checks++;
      if (shoot !== exp) begin
        errors++;
        $display("FAIL shoot_cooldown c=%0d shoot=%b expected=%b", c, shoot, exp);
      end
      if (c == 4)  btn_shoot = 1'b0;
      if (c == 9)  btn_shoot = 1'b1;
      if (c == 13) btn_shoot = 1'b0;
      if (c == 17) btn_shoot = 1'b1;
      if (c == 30) btn_shoot = 1'b0;
    end
    idle(10);
  endtask

  task automatic test_reset_mid();
    logic exp_rr, exp_mv, exp_held;
    btn_rst   = 1'b1;
    btn_right = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp_rr   = (c == 7) || (c == 20);
      exp_mv   = (c == 7) || (c == 20) || (c == 28);
      exp_held = ((c >= 6) && (c <= 12)) || (c >= 19);
      checks++;
      if (reset_req !== exp_rr) begin
        errors++;
        $display("FAIL reset_req c=%0d reset_req=%b expected=%b", c, reset_req, exp_rr);
      end
      checks++;
      if (move_right !== exp_mv) begin
        errors++;
        $display("FAIL rst_move c=%0d move_right=%b expected=%b", c, move_right, exp_mv);
      end
      checks++;
      if (right_held !== exp_held) begin
        errors++;
        $display("FAIL rst_held c=%0d right_held=%b expected=%b", c, right_held, exp_held);
      end
      if (c == 13) begin
        checks++;
        if ({move_right, move_left, shoot, reset_req, right_held, left_held} !== 6'b0) begin
          errors++;
          $display("FAIL mid_reset_outputs got=%b expected=000000",
                   {move_right, move_left, shoot, reset_req, right_held, left_held});
        end
      end
      if (c == 12) rst = 1'b1;
      if (c == 13) rst = 1'b0;
    end
    btn_rst   = 1'b0;
    btn_right = 1'b0;
    idle(10);
  endtask

  initial begin
    test_reset();
    test_shoot_hold();
    test_glitch();
    test_right_hold();
    test_both_held();
    test_shoot_cooldown();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Input-conditioning stage between the board push-buttons and the game core, clocked by the 100 MHz system clock. It synchronises and debounces the four raw buttons (right, left, shoot, reset). It converts them into clean single-cycle game events: move ticks with auto-repeat, rate-limited shots and a reset request. The game core consumes only these events and never sees raw button levels.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000, cycles a synchronised level must persist before being accepted (10 ms); ≥2.
- `MOVE_PERIOD`, 2_000_000, cycles between auto-repeat move ticks while a direction is held; ≥2.
- `SHOOT_COOLDOWN`, 25_000_000, cycles after a shot during which new shoot presses are discarded; ≥1.
- `CNT_W`, 25, counter width; must hold the largest of the three cycle parameters.

Ports:
- `clk` in 1: system clock, 100 MHz, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_right`, `btn_left`, `btn_shoot`, `btn_rst` in 1 each: raw asynchronous button levels, active-high.
- `move_right`, `move_left` out 1 each: one-cycle move tick.
- `shoot` out 1: one-cycle fire event.
- `reset_req` out 1: one-cycle game-reset request.
- `right_held`, `left_held` out 1 each: debounced levels.

## Operation
- Per button: 2-FF synchroniser, then debouncer with state `stable` (reset 0) and counter `cnt` (reset 0).
  - While the sync output equals `stable`, `cnt` is 0.
  - While they differ, `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and they still differ, `stable` flips and `cnt` clears.
  - Any return to equality before that point clears `cnt`; the glitch is dropped.
  - Each debouncer emits `rise`: 1 in the cycle after `stable` goes 0→1.
- Movement uses a shared repeat timer `rpt` (reset 0) and a direction register.
  - Exactly one of left/right stable-held: the tick fires with that direction's `rise`. `rpt` then counts, and another tick fires each time `rpt` reaches `MOVE_PERIOD-1` (`rpt` wraps to 0).
  - Both held, or neither held: no ticks, and `rpt` is held at 0.
  - Releasing one of two held directions makes the remaining one active. Its first tick fires immediately (next cycle), then repeats every `MOVE_PERIOD` cycles.
  - `move_left` and `move_right` are never high together.
- Shoot uses two-state FSM {READY, COOLDOWN} with counter `cd`.
  - READY + shoot `rise`: `shoot`=1 for one cycle, go to COOLDOWN, `cd`=0.
  - COOLDOWN: `cd` increments; at `cd == SHOOT_COOLDOWN-1` go to READY.
  - A `rise` during COOLDOWN is discarded, not queued.
  - Holding the button fires once; a new shot needs release and re-press.
- `reset_req` = btn_rst `rise`. The block does not reset itself on `reset_req`; the top level decides what it resets.
- `rst` mid-operation: every register (sync FFs, `stable`, counters, FSM) returns to reset value on the next edge. A button held through reset is re-debounced from 0 and produces a fresh `rise`.

## Timing
- All outputs are registered and 0 in reset. FSM resets to READY.
- Latency from the first edge sampling a new raw level to the `held` change is 2 + `DEBOUNCE_CYCLES` edges. The event pulse (`move_*`, `shoot`, `reset_req`) follows one edge later.
- Release latency is identical; release produces no pulse.
- Repeat tick spacing is exactly `MOVE_PERIOD` cycles. Shot spacing is at least `SHOOT_COOLDOWN` + 1 cycles.
- Every event pulse is exactly 1 cycle wide. No handshake: the consumer must sample every cycle.

## Structure
- Shared package `si_pkg`:
  - `CLK_HZ` = 100_000_000.
  - Default debounce, move and cooldown constants.
  - Shoot FSM state enum.
- Sub-module `btn_debounce` (synchroniser + debouncer + `rise`): parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst`, `btn_in`, `level`, `rise`. Instantiated four times.
- Repeat and cooldown logic live in `btn_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `MOVE_PERIOD`=8, `SHOOT_COOLDOWN`=16.
- Hold `btn_shoot`=1 from cycle 10 for 100 cycles → one `shoot` pulse at cycle 17 only; none after.
- Toggle `btn_left` 1/0 every 2 cycles for 40 cycles, then leave it 0 → no `move_left` pulses, `left_held` stays 0.
- Hold `btn_right` for 40 cycles from cycle 0 → `move_right` at cycles 7, 15, 23, 31, 39. Release → `right_held` falls 6 cycles after the release edge.
- Hold left, then hold right as well → ticks stop while both are held. Release left → `move_right` fires the next cycle, then every 8 cycles.
- Shoot pressed, released, re-pressed 10 cycles after the first shot → second press discarded. A re-press after 17+ cycles fires.
- Assert `rst` for 1 cycle while `btn_rst` is held and debounced → all outputs 0. `reset_req` pulses again 7 cycles after `rst` deasserts.
